sram_arbiter: RTL and testbench

Shares a single SRAM-like master port (toward the AXI bridge) between the instruction-fetch requester and the data-memory requester. It arbitrates address phases and locks a grant until the master accepts it. Returning data is routed back in order through an owner FIFO, so several transactions can be outstanding. Sits between the IF/MEM SRAM-like front ends and the SRAM-to-AXI bridge.

---
 rtl/sram_arb_pkg.sv | 26 ++
 rtl/owner_fifo.sv | 99 +++++++++
 rtl/sram_arbiter.sv | 169 ++++++++++++++++
 tb/tb_sram_arbiter.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arb_pkg
//  Description : Shared types and constants for the SRAM-like arbiter.
//                owner_t names a requester, state_t is the grant FSM state,
//                SIZE_* are the SRAM-like transfer size encodings.
//  Revision    : 1.0  initial release
// ============================================================================
package sram_arb_pkg;

    typedef enum logic [0:0] {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage
`default_nettype wire

// File: rtl/owner_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : owner_fifo
//  Description : Small FIFO of 1-bit owner tags recording which requester
//                owns each accepted-but-unreturned transaction.
//  Ports       : clk, rst   clock, synchronous active-high reset
//                push, din  enqueue an owner (ignored when full)
//                pop, dout  dequeue the head owner (ignored when empty)
//                full/empty occupancy flags
//  Parameters  : DEPTH      number of entries, power of two, >= 1
//  Revision    : 1.0  initial release
// ============================================================================
module owner_fifo
    import sram_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  logic   pop,
    input  owner_t din,
    output owner_t dout,
    output logic   full,
    output logic   empty
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign full   = (r_count == CW'(DEPTH));
    assign empty  = (r_count == '0);
    // A push while full is dropped even if a pop happens in the same cycle.
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
        end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
        end
    end

    generate
        if (DEPTH == 1) begin : g_single
            // One slot: no pointers needed, the slot is always the head.
            owner_t r_slot;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_slot <= OWNER_INST;
                end else if (w_push) begin
                    r_slot <= din;
                end
            end

            assign dout = r_slot;
        end else begin : g_ring
            localparam int PW = $clog2(DEPTH);

            owner_t        r_mem [DEPTH];
            logic [PW-1:0] r_wr_ptr;
            logic [PW-1:0] r_rd_ptr;
            logic [PW-1:0] w_wr_ptr_nxt;
            logic [PW-1:0] w_rd_ptr_nxt;

            assign w_wr_ptr_nxt = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            assign w_rd_ptr_nxt = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        r_mem[i] <= OWNER_INST;
                    end
                end else begin
                    if (w_push) begin
                        r_mem[r_wr_ptr] <= din;
                        r_wr_ptr        <= w_wr_ptr_nxt;
                    end
                    if (w_pop) begin
                        r_rd_ptr <= w_rd_ptr_nxt;
                    end
                end
            end

            assign dout = r_mem[r_rd_ptr];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arbiter
//  Description : Shares one SRAM-like master port between the instruction
//                and data requesters. The address phase is arbitrated and the
//                grant is held until the master accepts it; an owner FIFO
//                routes returning data back in order, allowing up to
//                OUTSTANDING transactions in flight.
//  Ports       : clk, rst                     clock, sync active-high reset
//                inst_* / data_*              SRAM-like slave ports
//                m_*                          SRAM-like master port
//  Parameters  : OUTSTANDING                  max accepted-but-unreturned
//  Macros      : ARB_ROUND_ROBIN_EN           round-robin arbitration when
//                                             defined, otherwise fixed
//                                             priority (data over inst)
//  Revision    : 1.0  initial release
// ============================================================================
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok
);

    state_t r_state;
    state_t w_state_nxt;
    owner_t r_lock_owner;
    owner_t w_lock_owner_nxt;
    owner_t w_winner;
    owner_t w_sel;
    owner_t w_head;
    logic   w_full;
    logic   w_empty;
    logic   w_grant;
    logic   w_push;
    logic   w_pop;

`ifdef ARB_ROUND_ROBIN_EN
    owner_t r_last_grant;

    // Remembers the most recently accepted owner so a contest favours the other.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= OWNER_INST;
        end else if (w_push) begin
            r_last_grant <= w_sel;
        end
    end
`endif

    // Winner among the live requests; only meaningful in IDLE.
    always_comb begin
        w_winner = OWNER_INST;
        if (inst_req && data_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            w_winner = (r_last_grant == OWNER_INST) ? OWNER_DATA : OWNER_INST;
`else
            w_winner = OWNER_DATA;
`endif
        end else if (data_req) begin
            w_winner = OWNER_DATA;
        end
    end

    // A held grant overrides arbitration; full FIFO suppresses the request
    // without disturbing the held grant.
    assign w_sel   = (r_state == LOCK) ? r_lock_owner : w_winner;
    assign w_grant = !w_full && ((r_state == LOCK) || inst_req || data_req);
    assign w_push  = w_grant && m_addr_ok;
    assign w_pop   = m_data_ok && !w_empty;

    always_comb begin
        m_req   = w_grant;
        m_wr    = 1'b0;
        m_size  = 2'd0;
        m_addr  = 32'd0;
        m_wdata = 32'd0;
        if (w_grant) begin
            if (w_sel == OWNER_DATA) begin
                m_wr    = data_wr;
                m_size  = data_size;
                m_addr  = data_addr;
                m_wdata = data_wdata;
            end else begin
                m_wr    = inst_wr;
                m_size  = inst_size;
                m_addr  = inst_addr;
                m_wdata = inst_wdata;
            end
        end
    end

    assign inst_addr_ok = w_push && (w_sel == OWNER_INST);
    assign data_addr_ok = w_push && (w_sel == OWNER_DATA);
    assign inst_data_ok = w_pop && (w_head == OWNER_INST);
    assign data_data_ok = w_pop && (w_head == OWNER_DATA);
    assign inst_rdata   = m_rdata;
    assign data_rdata   = m_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_lock_owner <= OWNER_INST;
        end else begin
            r_state      <= w_state_nxt;
            r_lock_owner <= w_lock_owner_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_lock_owner_nxt = r_lock_owner;
        case (r_state)
            IDLE: begin
                if (w_grant && !m_addr_ok) begin
                    w_state_nxt      = LOCK;
                    w_lock_owner_nxt = w_winner;
                end
            end
            LOCK: begin
                if (w_push) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    owner_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_owner_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_sel),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_arbiter
//  Description : Self-checking bench for sram_arbiter: directed scenarios
//                followed by randomized traffic checked against a
//                transaction-level model (owner queue + pending grant).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sram_arbiter;

    localparam int OUTSTANDING = 2;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size, m_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic        m_req, m_wr, m_addr_ok, m_data_ok;
    logic [31:0] m_addr, m_wdata, m_rdata;

    always #5 clk = ~clk;

    sram_arbiter #(.OUTSTANDING(OUTSTANDING)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_addr_ok(m_addr_ok),
        .m_data_ok(m_data_ok)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: queue of owners in flight (0=inst, 1=data), the
    // requester currently holding an unaccepted grant (-1 none) and the
    // last accepted owner for round-robin.
    int mq[$];
    int m_hold = -1;
    int m_last = 0;

    logic        e_req, e_wr, e_iaok, e_daok, e_idok, e_ddok;
    logic [1:0]  e_size;
    logic [31:0] e_addr, e_wdata;
    int          e_cand;
    bit          e_acc, e_ret;

    task automatic predict();
        int  cand;
        bit  granted;
        cand = -1;
        if (m_hold >= 0)                cand = m_hold;
        else if (inst_req && data_req)  cand = RR ? ((m_last == 1) ? 0 : 1) : 1;
        else if (data_req)              cand = 1;
        else if (inst_req)              cand = 0;
        granted = (cand >= 0) && (mq.size() < OUTSTANDING);
        e_cand  = cand;
        e_req   = granted;
        e_wr    = granted ? ((cand == 1) ? data_wr    : inst_wr)    : 1'b0;
        e_size  = granted ? ((cand == 1) ? data_size  : inst_size)  : 2'd0;
        e_addr  = granted ? ((cand == 1) ? data_addr  : inst_addr)  : 32'd0;
        e_wdata = granted ? ((cand == 1) ? data_wdata : inst_wdata) : 32'd0;
        e_acc   = granted && m_addr_ok;
        e_iaok  = e_acc && (cand == 0);
        e_daok  = e_acc && (cand == 1);
        e_ret   = m_data_ok && (mq.size() > 0);
        e_idok  = 1'b0;
        e_ddok  = 1'b0;
        if (e_ret) begin
            e_idok = (mq[0] == 0);
            e_ddok = (mq[0] == 1);
        end
    endtask

    // Commit one clock of the model using the currently driven inputs and
    // advance to the next falling edge.
    task automatic tick();
        predict();
        if (rst) begin
            mq.delete();
            m_hold = -1;
            m_last = 0;
        end else begin
            if (e_ret) void'(mq.pop_front());
            if (e_acc) begin
                mq.push_back(e_cand);
                m_hold = -1;
                m_last = e_cand;
            end else if (e_req) begin
                m_hold = e_cand;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 0; data_wdata = 0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        @(negedge clk);
        tick();
        tick();
        rst = 0;
        m_rdata = 32'hA5A5_0001;
        #1;
        n_vec++;
        if ({m_req, m_wr, m_size, m_addr, m_wdata, inst_addr_ok, data_addr_ok,
             inst_data_ok, data_data_ok} !== 72'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got req=%b addr=%h aok=%b%b dok=%b%b required all zero",
                     m_req, m_addr, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok);
        end
        n_vec++;
        if ({inst_rdata, data_rdata} !== {32'hA5A5_0001, 32'hA5A5_0001}) begin
            n_err++;
            $display("FAIL reset_rdata_fanout: got %h/%h required a5a50001", inst_rdata, data_rdata);
        end
        tick();
    endtask

    task automatic test_inst_read();
        inst_req = 1; inst_addr = 32'hBFC0_0000; m_addr_ok = 1;
        #1;
        n_vec++;
        if ({m_req, m_addr, inst_addr_ok, data_addr_ok} !== {1'b1, 32'hBFC0_0000, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL inst_read_addr: got req=%b addr=%h aok=%b%b required 1 bfc00000 10",
                     m_req, m_addr, inst_addr_ok, data_addr_ok);
        end
        tick();
        inst_req = 0; m_addr_ok = 0;
        tick();
        m_data_ok = 1; m_rdata = 32'h3C08_0000;
        #1;
        n_vec++;
        if ({inst_data_ok, data_data_ok, inst_rdata} !== {2'b10, 32'h3C08_0000}) begin
            n_err++;
            $display("FAIL inst_read_data: got dok=%b%b rdata=%h required 10 3c080000",
                     inst_data_ok, data_data_ok, inst_rdata);
        end
        tick();
        m_data_ok = 0;
    endtask

    task automatic test_priority();
        int w1, w2;
        w1 = 1;
        w2 = RR ? 0 : 1;
        inst_req = 1; inst_addr = 32'h0000_1000;
        data_req = 1; data_addr = 32'h0000_2000;
        m_addr_ok = 1;
        #1;
        n_vec++;
        if ({m_addr, data_addr_ok, inst_addr_ok} !==
            {((w1 == 1) ? 32'h0000_2000 : 32'h0000_1000), (w1 == 1), (w1 == 0)}) begin
            n_err++;
            $display("FAIL priority_contest1: got addr=%h aok(d,i)=%b%b required winner %0d",
                     m_addr, data_addr_ok, inst_addr_ok, w1);
        end
        tick();
        data_addr = 32'h0000_2004;
        #1;
        n_vec++;
        if ({m_addr, data_addr_ok, inst_addr_ok} !==
            {((w2 == 1) ? 32'h0000_2004 : 32'h0000_1000), (w2 == 1), (w2 == 0)}) begin
            n_err++;
            $display("FAIL priority_contest2: got addr=%h aok(d,i)=%b%b required winner %0d",
                     m_addr, data_addr_ok, inst_addr_ok, w2);
        end
        tick();
        inst_req = 0; data_req = 0; m_addr_ok = 0; m_data_ok = 1;
        #1;
        n_vec++;
        if ({inst_data_ok, data_data_ok} !== {(w1 == 0), (w1 == 1)}) begin
            n_err++;
            $display("FAIL priority_return1: got dok(i,d)=%b%b required owner %0d",
                     inst_data_ok, data_data_ok, w1);
        end
        tick();
        #1;
        n_vec++;
        if ({inst_data_ok, data_data_ok} !== {(w2 == 0), (w2 == 1)}) begin
            n_err++;
            $display("FAIL priority_return2: got dok(i,d)=%b%b required owner %0d",
                     inst_data_ok, data_data_ok, w2);
        end
        tick();
        m_data_ok = 0;
    endtask

    task automatic test_lock();
        inst_req = 1; inst_addr = 32'h0000_00C0; m_addr_ok = 0;
        data_addr = 32'h0000_00D0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) data_req = 1;
            #1;
            n_vec++;
            if ({m_req, m_addr, inst_addr_ok, data_addr_ok} !== {1'b1, 32'h0000_00C0, 2'b00}) begin
                n_err++;
                $display("FAIL lock_hold cycle %0d: got req=%b addr=%h aok=%b%b required 1 000000c0 00",
                         c, m_req, m_addr, inst_addr_ok, data_addr_ok);
            end
            tick();
        end
        m_addr_ok = 1;
        #1;
        n_vec++;
        if ({m_addr, inst_addr_ok, data_addr_ok} !== {32'h0000_00C0, 2'b10}) begin
            n_err++;
            $display("FAIL lock_accept: got addr=%h aok=%b%b required 000000c0 10",
                     m_addr, inst_addr_ok, data_addr_ok);
        end
        tick();
        inst_req = 0;
        #1;
        n_vec++;
        if ({m_addr, inst_addr_ok, data_addr_ok} !== {32'h0000_00D0, 2'b01}) begin
            n_err++;
            $display("FAIL lock_then_data: got addr=%h aok=%b%b required 000000d0 01",
                     m_addr, inst_addr_ok, data_addr_ok);
        end
        tick();
        data_req = 0; m_addr_ok = 0; m_data_ok = 1;
        tick();
        tick();
        m_data_ok = 0;
    endtask

    task automatic test_full();
        inst_req = 1; inst_addr = 32'h0000_00E0; m_addr_ok = 1;
        tick();
        inst_req = 0; data_req = 1; data_addr = 32'h0000_00F0;
        tick();
        data_req = 0; inst_req = 1; inst_addr = 32'h0000_00E4;
        #1;
        n_vec++;
        if ({m_req, inst_addr_ok, data_addr_ok} !== 3'b000) begin
            n_err++;
            $display("FAIL full_blocks: got req=%b aok=%b%b required 000", m_req, inst_addr_ok, data_addr_ok);
        end
        tick();
        m_data_ok = 1;
        #1;
        n_vec++;
        if ({m_req, inst_addr_ok, inst_data_ok, data_data_ok} !== 4'b0010) begin
            n_err++;
            $display("FAIL full_pop_same_cycle: got req=%b iaok=%b dok=%b%b required 0 0 10",
                     m_req, inst_addr_ok, inst_data_ok, data_data_ok);
        end
        tick();
        m_data_ok = 0;
        #1;
        n_vec++;
        if ({m_req, m_addr, inst_addr_ok} !== {1'b1, 32'h0000_00E4, 1'b1}) begin
            n_err++;
            $display("FAIL full_released: got req=%b addr=%h iaok=%b required 1 000000e4 1",
                     m_req, m_addr, inst_addr_ok);
        end
        tick();
        inst_req = 0; m_addr_ok = 0; m_data_ok = 1;
        #1;
        n_vec++;
        if ({inst_data_ok, data_data_ok} !== 2'b01) begin
            n_err++;
            $display("FAIL full_return_data: got dok=%b%b required 01", inst_data_ok, data_data_ok);
        end
        tick();
        #1;
        n_vec++;
        if ({inst_data_ok, data_data_ok} !== 2'b10) begin
            n_err++;
            $display("FAIL full_return_inst: got dok=%b%b required 10", inst_data_ok, data_data_ok);
        end
        tick();
        m_data_ok = 0;
    endtask

    task automatic test_push_pop();
        inst_req = 1; inst_addr = 32'h0000_0100; m_addr_ok = 1;
        tick();
        inst_req = 0; data_req = 1; data_addr = 32'h0000_0200; m_data_ok = 1;
        #1;
        n_vec++;
        if ({data_addr_ok, inst_data_ok, data_data_ok} !== 3'b110) begin
            n_err++;
            $display("FAIL push_pop_same: got daok=%b dok=%b%b required 1 10",
                     data_addr_ok, inst_data_ok, data_data_ok);
        end
        tick();
        data_req = 0; m_addr_ok = 0;
        #1;
        n_vec++;
        if ({inst_data_ok, data_data_ok} !== 2'b01) begin
            n_err++;
            $display("FAIL push_pop_next: got dok=%b%b required 01", inst_data_ok, data_data_ok);
        end
        tick();
        #1;
        n_vec++;
        if ({inst_data_ok, data_data_ok} !== 2'b00) begin
            n_err++;
            $display("FAIL push_pop_empty: got dok=%b%b required 00", inst_data_ok, data_data_ok);
        end
        tick();
        m_data_ok = 0;
    endtask

    task automatic test_reset_mid();
        inst_req = 1; inst_addr = 32'h0000_0300; m_addr_ok = 1;
        tick();
        inst_req = 0; data_req = 1; data_addr = 32'h0000_0400;
        tick();
        data_req = 0; m_addr_ok = 0;
        rst = 1;
        tick();
        rst = 0; m_data_ok = 1;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_vec++;
            if ({inst_data_ok, data_data_ok} !== 2'b00) begin
                n_err++;
                $display("FAIL reset_mid_stray %0d: got dok=%b%b required 00", c, inst_data_ok, data_data_ok);
            end
            tick();
        end
        m_data_ok = 0; inst_req = 1; m_addr_ok = 1;
        for (int c = 0; c < 2; c++) begin
            inst_addr = 32'h0000_0500 + 32'(c * 4);
            #1;
            n_vec++;
            if ({m_req, inst_addr_ok} !== 2'b11) begin
                n_err++;
                $display("FAIL reset_mid_empty %0d: got req=%b iaok=%b required 11", c, m_req, inst_addr_ok);
            end
            tick();
        end
        inst_req = 0; m_addr_ok = 0; m_data_ok = 1;
        tick();
        tick();
        m_data_ok = 0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if (!inst_req && ($urandom_range(0, 2) == 0)) begin
                inst_req = 1; inst_wr = ($urandom_range(0, 7) == 0);
                inst_size = 2'($urandom_range(0, 2)); inst_addr = $urandom; inst_wdata = $urandom;
            end
            if (!data_req && ($urandom_range(0, 1) == 0)) begin
                data_req = 1; data_wr = 1'($urandom);
                data_size = 2'($urandom_range(0, 2)); data_addr = $urandom; data_wdata = $urandom;
            end
            m_addr_ok = 1'($urandom);
            m_data_ok = ($urandom_range(0, 2) != 0);
            m_rdata   = $urandom;
            #1;
            predict();
            n_vec++;
            if ({m_req, m_wr, m_size, m_addr, m_wdata} !== {e_req, e_wr, e_size, e_addr, e_wdata}) begin
                n_err++;
                $display("FAIL rand_master cycle %0d: got req=%b wr=%b size=%0d addr=%h wdata=%h required req=%b wr=%b size=%0d addr=%h wdata=%h",
                         c, m_req, m_wr, m_size, m_addr, m_wdata, e_req, e_wr, e_size, e_addr, e_wdata);
            end
            n_vec++;
            if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== {e_iaok, e_daok, e_idok, e_ddok}) begin
                n_err++;
                $display("FAIL rand_handshake cycle %0d: got aok=%b%b dok=%b%b required aok=%b%b dok=%b%b",
                         c, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, e_iaok, e_daok, e_idok, e_ddok);
            end
            n_vec++;
            if ({inst_rdata, data_rdata} !== {m_rdata, m_rdata}) begin
                n_err++;
                $display("FAIL rand_rdata cycle %0d: got %h/%h required %h", c, inst_rdata, data_rdata, m_rdata);
            end
            tick();
            if (e_iaok) inst_req = 0;
            if (e_daok) data_req = 0;
        end
        idle_inputs();
        m_data_ok = 1;
        for (int c = 0; c < OUTSTANDING + 1; c++) tick();
        m_data_ok = 0;
    endtask

    initial begin
        test_reset();
        test_inst_read();
        test_priority();
        test_lock();
        test_full();
        test_push_pop();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
